conv2d_mem_if: RTL and testbench

Memory-side adapter for the conv2D accelerator. It takes the accelerator's word-addressed request stream (valid/ready, with read/write select) and drives a synchronous single-port block RAM with fixed read latency. Read data comes back in order through a response FIFO on a valid/ready channel. Credit-based admission guarantees the FIFO never overflows while the consumer stalls `mem_resp_ready`.

---
 rtl/conv2d_mem_if.sv | 72 +++++++
 tb/tb_conv2d_mem_if.sv | 117 +++++++++++
 2 files changed

// File: rtl/conv2d_mem_if.sv
// conv2d_mem_if: request stream to block-RAM adapter with credit-limited in-order read response FIFO
module conv2d_mem_if #(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 14,
   parameter int MEM_LAT    = 2,
   parameter int RESP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       req_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DWIDTH-1:0] req_data,
   input  logic              req_write,
   output logic [DWIDTH-1:0] resp_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [AWIDTH-1:0] ram_addr,
   output logic              ram_en,
   output logic              ram_we,
   output logic [DWIDTH-1:0] ram_din,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic              idle,
   output logic              addr_err
);
   localparam int CW = $clog2(RESP_DEPTH) + 1;
   localparam int PW = $clog2(RESP_DEPTH);
   logic [CW-1:0]     outst, cnt;
   logic [MEM_LAT-1:0] tv, to;
   logic [DWIDTH-1:0] q [RESP_DEPTH];
   logic              in_range, accept, rd_acc, pop, push;
   logic [PW-1:0]     wi;
   logic [DWIDTH-1:0] push_data;
   assign in_range   = req_addr[31:AWIDTH] == '0;
   assign req_ready  = !rst & (req_write | (outst < CW'(RESP_DEPTH)));
   assign accept     = req_valid & req_ready;
   assign rd_acc     = accept & !req_write;
   assign ram_en     = accept & in_range;
   assign ram_we     = ram_en & req_write;
   assign ram_addr   = req_addr[AWIDTH-1:0];
   assign ram_din    = req_data;
   assign resp_valid = cnt != '0;
   assign resp_data  = q[0];
   assign pop        = resp_valid & resp_ready;
   assign push       = tv[MEM_LAT-1];
   assign push_data  = to[MEM_LAT-1] ? '0 : ram_dout;
   // credits guarantee the FIFO is not full whenever a tag reaches the last stage
   assign wi         = cnt[PW-1:0] - PW'(pop);
   assign idle       = outst == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         outst    <= '0;
         cnt      <= '0;
         tv       <= '0;
         to       <= '0;
         addr_err <= 1'b0;
      end else begin
         tv[0] <= rd_acc;
         to[0] <= !in_range;
         for (int i = 1; i < MEM_LAT; i++) begin
            tv[i] <= tv[i-1];
            to[i] <= to[i-1];
         end
         if (pop)
            for (int i = 0; i < RESP_DEPTH - 1; i++) q[i] <= q[i+1];
         if (push) q[wi] <= push_data;
         cnt   <= cnt + CW'(push) - CW'(pop);
         outst <= outst + CW'(rd_acc) - CW'(pop);
         if (accept & !in_range) addr_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_conv2d_mem_if.sv
// tb_conv2d_mem_if: randomized and directed checks of conv2d_mem_if against a transaction-level model
module tb_conv2d_mem_if;
   localparam int DW = 32, AW = 14, LAT = 2, DEP = 4;
   logic          clk = 0, rst = 1;
   logic [31:0]   req_addr = 0;
   logic          req_valid = 0, req_write = 0, resp_ready = 0;
   logic [DW-1:0] req_data = 0;
   logic          req_ready, resp_valid, ram_en, ram_we, idle, addr_err;
   logic [DW-1:0] resp_data, ram_din, ram_dout;
   logic [AW-1:0] ram_addr;
   int            n_tests = 0, n_fail = 0, cyc = 0;
   always #5 clk = ~clk;
   conv2d_mem_if #(.DWIDTH(DW), .AWIDTH(AW), .MEM_LAT(LAT), .RESP_DEPTH(DEP)) dut (
      .clk(clk), .rst(rst), .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_write(req_write), .resp_data(resp_data), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout), .idle(idle), .addr_err(addr_err));
   // environment RAM: registered read, LAT cycles to ram_dout
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [LAT];
   always @(posedge clk) begin
      if (ram_en & ram_we) ram[ram_addr] <= ram_din;
      rd_pipe[0] <= ram[ram_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_dout = rd_pipe[LAT-1];
   always @(posedge clk) cyc++;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   // model: every accepted read is an entry carrying its data and the cycle it becomes visible
   typedef struct { logic [DW-1:0] d; int t; } ent_t;
   ent_t q[$];
   logic m_err = 0, inr, exp_rdy, exp_v, acc;
   always @(negedge clk) begin
      if (rst) begin
         chk("req_ready_in_reset", req_ready, 0);
         chk("ram_en_in_reset", ram_en, 0);
         q.delete();
         m_err = 0;
      end else begin
         inr = req_addr < 32'(1 << AW);
         exp_rdy = req_write | (q.size() < DEP);
         exp_v = q.size() > 0 && q[0].t <= cyc;
         acc = req_valid & exp_rdy;
         chk("req_ready", req_ready, exp_rdy);
         chk("idle", idle, q.size() == 0);
         chk("addr_err", addr_err, m_err);
         chk("resp_valid", resp_valid, exp_v);
         if (exp_v) chk("resp_data", resp_data, q[0].d);
         chk("ram_en", ram_en, acc & inr);
         chk("ram_we", ram_we, acc & inr & req_write);
         if (acc & inr) begin
            chk("ram_addr", ram_addr, req_addr[AW-1:0]);
            if (req_write) chk("ram_din", ram_din, req_data);
         end
         if (exp_v & resp_ready) void'(q.pop_front());
         if (acc) begin
            if (!inr) m_err = 1;
            if (req_write) begin
               if (inr) shadow[req_addr[AW-1:0]] = req_data;
            end else q.push_back('{inr ? shadow[req_addr[AW-1:0]] : '0, cyc + LAT + 1});
         end
      end
   end
   task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [DW-1:0] d, input logic rr);
      req_valid = v; req_write = w; req_addr = a; req_data = d; resp_ready = rr;
      @(posedge clk); #1;
   endtask
   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = $urandom;
         shadow[i] = ram[i];
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      step(1, 1, 5, 32'hDEADBEEF, 1);
      step(1, 0, 5, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, 1, i, i, 1);
      for (int i = 0; i < 16; i++) step(1, 0, i, 0, 1);
      repeat (6) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 0, i + 8, 0, 0);
      step(1, 1, 100, 32'hAA, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 7, 0, 0);
      repeat (8) step(0, 0, 0, 0, 1);
      step(1, 0, 32'h4000, 0, 1);
      step(1, 1, 32'h4003, 32'h1234, 1);
      step(1, 0, 3, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 0, i, 0, 0);
      rst = 1;
      step(0, 0, 0, 0, 0);
      rst = 0;
      repeat (6) step(0, 0, 0, 0, 1);
      for (int n = 0; n < 1500; n++) begin
         rst = $urandom_range(0, 299) == 0;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 19) == 0 ? 32'h4000 + $urandom_range(0, 15) : 32'($urandom_range(0, 31)),
              $urandom, $urandom_range(0, 3) != 0);
         rst = 0;
      end
      req_valid = 0;
      resp_ready = 1;
      for (int i = 0; i < 50 && !idle; i++) @(posedge clk);
      #1 chk("drain_idle", idle, 1);
      chk("ram_word3", ram[3], shadow[3]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
